// File: rtl/first_one_isolator_seq.sv
// Sequential first-one isolator: scans a WIDTH-bit request SEG bits per cycle.
// Supports fixed priority (bit 0 highest) and round-robin priority past the last grant.
module first_one_isolator_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 8,
    parameter int unsigned IW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic [IW-1:0]    out_index,
    output logic             out_none
);

    localparam int unsigned NSEG = WIDTH / SEG;
    localparam int unsigned SW   = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int unsigned OW   = (SEG > 1) ? $clog2(SEG) : 1;
    localparam int unsigned CW   = $clog2(NSEG + 2);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] vec_q;
    logic             mode_q;
    logic [SW-1:0]    seg_q;
    logic [CW-1:0]    cnt_q;
    logic [IW-1:0]    ptr_q;

    logic [SW-1:0]    start_seg;
    logic [OW-1:0]    ptr_off;
    logic [SW-1:0]    next_seg;
    logic [SEG-1:0]   seg_bits;
    logic [SEG-1:0]   seg_en;
    logic             hit;
    logic [OW-1:0]    hit_bit;
    logic [IW-1:0]    hit_index;
    logic             last_scan;
    logic             accept;
    logic             release_out;

    assign accept      = in_valid & in_ready;
    assign release_out = out_valid & out_ready;
    assign start_seg   = SW'(ptr_q / IW'(SEG));
    assign ptr_off     = OW'(ptr_q % IW'(SEG));
    assign next_seg    = (seg_q == SW'(NSEG - 1)) ? '0 : seg_q + SW'(1);
    assign hit_index   = IW'(int'(seg_q) * int'(SEG) + int'(hit_bit));
    assign last_scan   = mode_q ? (cnt_q == CW'(NSEG)) : (cnt_q == CW'(NSEG - 1));

    // Round-robin masks the start segment: bits at/above ptr first, bits below ptr on the revisit.
    always_comb begin
        seg_bits = SEG'(vec_q >> (int'(seg_q) * int'(SEG)));
        seg_en   = '1;
        hit      = 1'b0;
        hit_bit  = '0;
        for (int i = 0; i < int'(SEG); i++) begin
            if (mode_q && (cnt_q == '0)) begin
                seg_en[i] = (OW'(i) >= ptr_off);
            end else if (mode_q && (cnt_q == CW'(NSEG))) begin
                seg_en[i] = (OW'(i) < ptr_off);
            end
        end
        for (int i = int'(SEG) - 1; i >= 0; i--) begin
            if (seg_bits[i] && seg_en[i]) begin
                hit     = 1'b1;
                hit_bit = OW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid)               state_d = SCAN;
            SCAN: if (hit || last_scan)       state_d = DONE;
            DONE: if (out_ready)              state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // Handshake flags are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q      <= '0;
            mode_q     <= 1'b0;
            seg_q      <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            out_onehot <= '0;
            out_index  <= '0;
            out_none   <= 1'b0;
        end else begin
            if (accept) begin
                vec_q  <= in_vec;
                mode_q <= in_mode;
                seg_q  <= in_mode ? start_seg : '0;
                cnt_q  <= '0;
            end
            if (state_q == SCAN) begin
                if (hit) begin
                    out_onehot <= WIDTH'(1) << hit_index;
                    out_index  <= hit_index;
                    out_none   <= 1'b0;
                end else if (last_scan) begin
                    out_onehot <= '0;
                    out_index  <= '0;
                    out_none   <= 1'b1;
                end else begin
                    seg_q <= next_seg;
                    cnt_q <= cnt_q + CW'(1);
                end
            end
            if (release_out && mode_q && !out_none) begin
                ptr_q <= (out_index == IW'(WIDTH - 1)) ? '0 : out_index + IW'(1);
            end
        end
    end

endmodule

// File: doc/first_one_isolator_seq.md
# first_one_isolator_seq

Parametrised, sequential successor to the team's 32-bit combinational first-one isolator. It accepts a WIDTH-bit request vector over a valid/ready handshake and scans it SEG bits per cycle, which bounds logic depth for the FHE-oriented flows. It returns a one-hot grant, the binary index of the granted bit and a none flag. It adds a round-robin mode, in which priority rotates past the last grant, alongside the legacy fixed-priority mode where bit 0 is highest.

## Interface
- WIDTH, 32: request vector width; must be a multiple of SEG.
- SEG, 8: bits examined per scan cycle; NSEG = WIDTH/SEG, NSEG ≥ 2.
- IW, $clog2(WIDTH): index width (derived).
- clk  in  1  the block's single clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request vector present.
- in_ready  out  1  block can accept a request.
- in_vec  in  WIDTH  request bits.
- in_mode  in  1  0 = fixed priority (bit 0 highest), 1 = round-robin.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- out_onehot  out  WIDTH  isolated bit, or 0 if there is no request bit.
- out_index  out  IW  index of the granted bit, or 0 if none.
- out_none  out  1  in_vec was all zero.

## Operation
- States: IDLE, SCAN, DONE. `in_ready = (state == IDLE)`. `out_valid = (state == DONE)`.
- IDLE: on `in_valid & in_ready`, the block latches in_vec and in_mode and enters SCAN.
- Start segment and first mask:
  - Fixed mode: start segment 0, no mask.
  - Round-robin mode: start segment `ptr/SEG`; bits below ptr in the start segment are masked off.
- SCAN visits one segment per cycle in ascending order, wrapping modulo NSEG.
  - In each visited segment, the lowest set unmasked bit wins.
  - On a hit, the block registers the one-hot and index and enters DONE.
- Scan count:
  - Fixed mode: at most NSEG scans.
  - Round-robin mode: at most NSEG+1 scans. Scan NSEG+1 revisits the start segment with only the bits below ptr enabled.
- Exhausted scan: out_none=1, out_onehot=0, out_index=0, then DONE.
- DONE: outputs are held stable until out_ready. On `out_valid & out_ready` the block returns to IDLE.
- Pointer ptr (IW bits, reset 0):
  - Updated only on the output handshake, only when the latched mode is round-robin and out_none=0.
  - Update rule: `ptr <= (out_index + 1) mod WIDTH`. From index WIDTH-1 it wraps to 0.
- Fixed-mode results never touch ptr.
- Reset, asserted at any time including mid-scan or in DONE: the block discards the pending request.
  - State IDLE, ptr=0.
  - Output reset values: out_valid=0, out_onehot=0, out_index=0, out_none=0.
  - in_ready=1 as soon as reset releases.

## Timing
- Accept edge at cycle T. Segment scan k (k = 0-based visit count) occurs in cycle T+1+k.
- A hit on visit k gives out_valid=1 from cycle T+2+k.
- Latency bounds:
  - Fixed mode: min 2, max NSEG+1.
  - Round-robin mode: max NSEG+2.
- An all-zero vector always takes the full scan count:
  - Fixed mode: valid at T+NSEG+1.
  - Round-robin mode: valid at T+NSEG+2.
- No overlap between requests: in_ready=0 from the accept cycle until the cycle after the output handshake. Throughput is one request per latency+1 cycles minimum.
- in_vec and in_mode are don't-care while in_ready=0.
- out_ready held high in DONE: a 1-cycle DONE, and in_ready rises the next cycle.

## Test plan
All scenarios use WIDTH=32, SEG=8.

1. Fixed mode, in_vec=0x0000_0006 accepted at T, out_ready=1 → out_valid at T+2; out_onehot=0x0000_0002, out_index=1, out_none=0; ptr stays 0.
2. Fixed mode, in_vec=0x8000_0000 → valid at T+5, onehot=0x8000_0000, index=31. Fixed mode, in_vec=0 → valid at T+5, none=1, onehot=0, index=0.
3. Round-robin mode, ptr=0, in_vec=0x0000_0101 issued three times:
   - First: index 0 at T+2, ptr→1.
   - Second: index 8 at T+3, ptr→9.
   - Third: segments 1(masked), 2, 3, 0 are scanned; index 0 at T+5, ptr→1.
4. Round-robin mode, ptr=9, in_vec=0x0000_0100 → NSEG+1 scans, with the last scan covering bits 8 only; valid at T+6, index 8, ptr→9. Round-robin mode, ptr=31, in_vec=0x8000_0000 → index 31, ptr wraps to 0.
5. Backpressure: hit result, out_ready=0 for 3 cycles → outputs bit-stable, in_ready=0, and any in_valid is ignored. out_ready=1 → handshake, then in_ready=1 next cycle.
6. rst_n pulsed low during scan 2 of a fixed-mode zero vector, with ptr previously 5 → all outputs 0 and ptr=0 immediately (asynchronous). After release, a new request 0x10 yields index 4 at T+2.
